// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data memory / load-store unit.
//   size_e      : access size encoding (2'b11 is reserved and handled as a word)
//   state_e     : clear/run sequencer states
//   lane_mask   : byte-lane write enables for a given size and low address
//   is_misaligned, align_lo : misalignment detection and align-down of addr[1:0]
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] m;
        case (size)
            SZ_B: begin
                case (lo)
                    2'd0:    m = 4'b0001;
                    2'd1:    m = 4'b0010;
                    2'd2:    m = 4'b0100;
                    default: m = 4'b1000;
                endcase
            end
            SZ_H:    m = lo[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic r;
        case (size)
            SZ_B:    r = 1'b0;
            SZ_H:    r = lo[0];
            default: r = (lo != 2'b00);
        endcase
        return r;
    endfunction

    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        logic [1:0] r;
        case (size)
            SZ_B:    r = lo;
            SZ_H:    r = {lo[1], 1'b0};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// data_mem_lsu_if: request/response bundle between the MEM stage and the data memory.
//   master drives : req, we, size, lu, aluout, store_data
//   slave drives  : ready, rvalid, read_data, wack, fault
interface data_mem_lsu_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              lu;
    logic [ADDR_W-1:0] aluout;
    logic [31:0]       store_data;
    logic              ready;
    logic              rvalid;
    logic [31:0]       read_data;
    logic              wack;
    logic              fault;

    modport master (
        output req, we, size, lu, aluout, store_data,
        input  ready, rvalid, read_data, wack, fault
    );

    modport slave (
        input  req, we, size, lu, aluout, store_data,
        output ready, rvalid, read_data, wack, fault
    );
endinterface

// File: rtl/dmem_extend.sv
// dmem_extend: combinational load-lane extraction and sign/zero extension.
//   size      in  2  : access size (reserved 2'b11 behaves as word)
//   lu        in  1  : 1 = zero-extend, 0 = sign-extend
//   addr_lo   in  2  : byte offset within the word (already aligned for half/word)
//   raw       in  32 : full memory word
//   read_data out 32 : extended result
module dmem_extend
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        lu,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] raw,
    output logic [31:0] read_data
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        case (addr_lo)
            2'd0:    b = raw[7:0];
            2'd1:    b = raw[15:8];
            2'd2:    b = raw[23:16];
            default: b = raw[31:24];
        endcase
        h = addr_lo[1] ? raw[31:16] : raw[15:0];

        case (size)
            SZ_B:    read_data = lu ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_H:    read_data = lu ? {16'h0, h} : {{16{h[15]}}, h};
            default: read_data = raw;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: DEPTH x 32-bit data memory with byte/half/word load-store unit.
// After reset a sequencer zeroes every word (CLEAR) before accepting requests (RUN).
// Loads and stores complete with one-cycle latency; fully pipelined.
//   clk, rst      : clock, asynchronous active-high reset
//   bus (slave)   : req/we/size/lu/aluout/store_data in; ready/rvalid/read_data/wack/fault out
//   branch, zero  : branch control and ALU zero flag
//   pcsrc         : branch & zero (combinational, independent of reset)
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned accesses are suppressed and flagged
// on fault; otherwise they are aligned down and fault stays 0.
module data_mem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    data_mem_lsu_if.slave  bus,
    input  logic           branch,
    input  logic           zero,
    output logic           pcsrc
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  idx;
    logic [1:0]        lo;
    logic              drop;
    logic              accept;
    logic              unused_addr;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [3:0]        wr_be;
    logic [31:0]       wr_data;

    logic              rvalid_q, wack_q;
    logic [31:0]       raw_q;
    logic [1:0]        sz_q;
    logic              lu_q;
    logic [1:0]        lo_q;

    assign pcsrc       = branch & zero;

    assign addr        = bus.aluout;
    assign idx         = addr[IDX_W+1:2];
    assign unused_addr = ^addr;
    assign accept      = (state_q == ST_RUN) && bus.req;
    assign bus.ready   = (state_q == ST_RUN);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign lo   = addr[1:0];
    assign drop = is_misaligned(bus.size, addr[1:0]);
`else
    assign lo   = align_lo(bus.size, addr[1:0]);
    assign drop = 1'b0;
`endif

    // Clear sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
    end

    // Single write port shared by the clear sequencer and stores. Store data is
    // replicated across lanes so the byte-enable mask alone picks the target lane.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_be   = '0;
        case (bus.size)
            SZ_B:    wr_data = {4{bus.store_data[7:0]}};
            SZ_H:    wr_data = {2{bus.store_data[15:0]}};
            default: wr_data = bus.store_data;
        endcase
        if (state_q == ST_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = cnt_q;
            wr_be   = '1;
            wr_data = '0;
        end else if (accept && bus.we && !drop) begin
            wr_en = 1'b1;
            wr_be = lane_mask(bus.size, lo);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Load capture: the raw word and access attributes are held until the next
    // load, so read_data stays stable between rvalid pulses. A store at edge N is
    // already in mem when a load at edge N+1 samples it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
            raw_q    <= '0;
            sz_q     <= '0;
            lu_q     <= 1'b0;
            lo_q     <= '0;
        end else begin
            rvalid_q <= accept && !bus.we;
            wack_q   <= accept && bus.we;
            if (accept && !bus.we) begin
                raw_q <= drop ? '0 : mem[idx];
                sz_q  <= bus.size;
                lu_q  <= bus.lu;
                lo_q  <= lo;
            end
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic fault_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= accept && drop;
        end
    end
    assign bus.fault = fault_q;
`else
    assign bus.fault = 1'b0;
`endif

    assign bus.rvalid = rvalid_q;
    assign bus.wack   = wack_q;

    dmem_extend u_extend (
        .size      (sz_q),
        .lu        (lu_q),
        .addr_lo   (lo_q),
        .raw       (raw_q),
        .read_data (bus.read_data)
    );

endmodule
